apb_master: RTL and testbench
=============================

# apb_master

APB requester that converts a simple valid/ready command stream into APB3 SETUP/ACCESS transfers toward one slave. It pairs with the team's `apb_slave` on the same PCLK domain: local logic issues single read or write commands, and the block returns one response per command with read data and error status.

## Interface
Parameters:
- ADDR_W, 8, PADDR width
- DATA_W, 32, PWDATA/PRDATA width
- TIMEOUT_CYCLES, 16, max ACCESS wait cycles before abort; used only with the timeout macro; must be ≥1

Ports:
- PCLK  in  1  sole clock, rising edge
- PRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  DATA_W  captured PRDATA for reads; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR captured, or timeout abort
- rsp_timeout  out  1  abort by timeout; tied 0 without the macro
- PSEL, PENABLE, PWRITE  out  1  APB controls
- PADDR  out  ADDR_W; PWDATA  out  DATA_W
- PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready = 1. On accept: latch write/addr/wdata; move to SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched values; move to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, with address/control/data held stable.
  - PREADY=0: remain in ACCESS.
  - PREADY=1 at the rising edge: capture PRDATA (reads only) and PSLVERR; go to IDLE; PSEL=PENABLE=0.
- Response: rsp_valid is high for exactly the first IDLE cycle after completion, with rsp_rdata, rsp_err, and rsp_timeout valid alongside it. cmd_ready is also 1 in that cycle.
- Commands presented outside IDLE are not accepted; cmd_ready = 0 in SETUP and ACCESS.
- PWDATA holds the last written value after a transfer; for reads it holds the previous value.
- PSLVERR and PRDATA are ignored unless PREADY=1 in ACCESS.

## Timing
- All APB outputs and rsp_* are registered. cmd_ready is decoded from state (IDLE).
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, cmd_ready=1 (state IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
- Zero-wait transfer:
  - accept edge N
  - SETUP in cycle N+1
  - ACCESS in cycle N+2 with PREADY=1
  - rsp_valid in cycle N+3
  - next accept possible at the edge ending N+3
  - minimum 3 cycles per transfer
- Each ACCESS cycle with PREADY=0 adds 1 cycle.
- PRESET asserted mid-transfer: at the next edge, all outputs take reset values and state returns to IDLE. The transfer is dropped and no rsp_valid is issued.
- PRESET has priority over all other inputs.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A wait counter clears on SETUP and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, the FSM goes to IDLE with PSEL=PENABLE=0.
  - It then pulses rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY=1 on the same edge the limit is reached counts as normal completion.
- Not defined: no counter; ACCESS waits indefinitely; rsp_timeout is constant 0.

## Structure
- Package apb_pkg:
  - state enum (IDLE, SETUP, ACCESS)
  - default ADDR_W/DATA_W localparams
  - TIMEOUT_CYCLES default
  - shared with apb_slave
- Sub-module apb_timeout_ctr: saturating wait counter with clear, enable, limit, and expired outputs. Instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write, zero-wait: cmd write addr 0x02, data 0xCAFEBABE.
  - SETUP cycle shows PSEL=1, PENABLE=0, PADDR=0x02, PWDATA=0xCAFEBABE.
  - ACCESS follows.
  - rsp_valid=1 for 1 cycle, rsp_err=0, 3 cycles accept-to-accept.
- Read with 2 wait states: addr 0x05, PREADY low for 2 ACCESS cycles then high with PRDATA=0xFEEDBEEF.
  - PENABLE stays high for 3 cycles.
  - rsp_rdata=0xFEEDBEEF.
- Slave error: write addr 0x20, data 0x0BADF00D, PSLVERR=1 with PREADY.
  - rsp_err=1, rsp_timeout=0.
- Back-to-back: cmd_valid held high with two writes (0x03/0xABCD1234, then 0x04/0x12345678).
  - Second accepted in the rsp_valid cycle.
  - PSEL drops for exactly 1 cycle between transfers.
- Reset mid-ACCESS: PRESET=1 while PENABLE=1.
  - Next edge: PSEL=PENABLE=0, no rsp_valid, cmd_ready=1.
- Timeout (macro on, TIMEOUT_CYCLES=4): PREADY held 0.
  - After 4 ACCESS cycles: PSEL=0, rsp_valid=1, rsp_err=1, rsp_timeout=1.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and defaults for the APB requester and completer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package apb_pkg;

  // Transfer phase of the APB requester FSM.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W         = 8;
  localparam int APB_DATA_W         = 32;
  localparam int APB_TIMEOUT_CYCLES = 16;

  // Counter width able to hold the value 'limit' itself.
  function automatic int apb_cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: saturating wait counter with synchronous clear and enable.
// Latency: count updates at the edge; expired is combinational from count/en/limit.
// Backpressure: none; expired flags that the current enabled cycle brings the count to limit.
module apb_timeout_ctr #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W:0]   count_inc;

  // One extra bit so the compare against limit cannot wrap.
  assign count_inc = {1'b0, count_q} + (CNT_W + 1)'(1);
  assign expired   = en && (count_inc >= {1'b0, limit});

  // Next count: clear wins, otherwise increment while enabled until all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_inc[CNT_W-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/apb_master.sv
// apb_master: valid/ready command stream to APB3 SETUP/ACCESS transfers, one rsp pulse per command.
// Latency: accept-to-rsp_valid 3 cycles, +1 per ACCESS cycle with PREADY=0.
// Backpressure: cmd_ready only in IDLE, rsp has none; APB_MASTER_TIMEOUT_EN bounds ACCESS waits.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = apb_cnt_w(TIMEOUT_CYCLES);

  logic ctr_clr;
  logic ctr_en;
  logic ctr_expired;
  logic rsp_timeout_q, rsp_timeout_d;

  // Wait count restarts every transfer and only advances on stalled ACCESS cycles.
  assign ctr_clr = (state_q == SETUP);
  assign ctr_en  = (state_q == ACCESS) && !PREADY;

  apb_timeout_ctr #(
    .CNT_W (CNT_W)
  ) u_timeout_ctr (
    .clk     (PCLK),
    .rst     (PRESET),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .limit   (CNT_W'(TIMEOUT_CYCLES)),
    .expired (ctr_expired)
  );

  // Timeout status register, aligned with the other rsp_* flops.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  // The wait limit only matters in the timeout build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES >= 1);
  assign rsp_timeout        = 1'b0;
`endif

  // Next-state and registered-output decode for the SETUP/ACCESS sequence.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          // Reads leave the previous write data on the bus.
          if (cmd_write) begin
            pwdata_d = cmd_wdata;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (ctr_expired) begin
          state_d       = IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any transfer in flight.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: drives commands, models a simple APB completer, scoreboards responses.
// Latency: expects 3-cycle zero-wait transfers plus one cycle per wait state.
// Backpressure: commands held until cmd_ready; responses checked on the cycle they appear.
module tb_apb_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } exp_t;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t exp_q[$];

  // Completer behaviour for the current transfer.
  int          sl_wait  = 0;
  logic [DW-1:0] sl_rdata = '0;
  logic        sl_err   = 1'b0;

  // Bus shape measurements.
  int en_run      = 0;
  int last_en_run = 0;
  int low_run     = 0;
  int last_gap    = 0;

  apb_master #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Completer: PREADY after sl_wait stalled ACCESS cycles; junk PRDATA/PSLVERR otherwise.
  initial begin
    int acc_n;
    acc_n   = 0;
    PREADY  = 1'b0;
    PRDATA  = 32'hDEAD_0000;
    PSLVERR = 1'b1;
    forever begin
      @(negedge PCLK);
      if (PSEL && PENABLE) begin
        PREADY  = (acc_n >= sl_wait);
        PRDATA  = PREADY ? sl_rdata : 32'hDEAD_0000 + 32'(acc_n);
        PSLVERR = PREADY ? sl_err : 1'b1;
        acc_n++;
      end else begin
        acc_n   = 0;
        PREADY  = 1'b0;
        PRDATA  = 32'hDEAD_BEEF;
        PSLVERR = 1'b1;
      end
    end
  end

  // Response monitor and bus-shape tracker.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        en_run  = 0;
        low_run = 0;
      end else begin
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            check_val("rsp_spurious", rsp_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check_val("rsp_rdata", rsp_rdata, e.rdata);
            check_val("rsp_err", rsp_err, e.err);
            check_val("rsp_timeout", rsp_timeout, e.to);
          end
        end
        if (PENABLE) begin
          en_run++;
        end else if (en_run > 0) begin
          last_en_run = en_run;
          en_run = 0;
        end
        if (PSEL) begin
          if (low_run > 0) last_gap = low_run;
          low_run = 0;
        end else begin
          low_run++;
        end
      end
    end
  end

  // Present one command at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input logic [DW-1:0] rd, input logic er,
                      input logic exp_to, output int acc_cyc, output logic rv_at_acc);
    int   n;
    exp_t e;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    acc_cyc   = cyc;
    rv_at_acc = rsp_valid;
    if (!cmd_ready) begin
      check_val("cmd_accept", cmd_ready, 1'b1);
    end else begin
      sl_wait  = waits;
      sl_rdata = rd;
      sl_err   = er;
      e.rdata  = (w || exp_to) ? '0 : rd;
      e.err    = er || exp_to;
      e.to     = exp_to;
      exp_q.push_back(e);
    end
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  // Wait until every pushed expectation has been answered.
  task automatic wait_rsp();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge PCLK);
      #1;
      n++;
    end
    check_val("rsp_count", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c1, c2;
    logic rv1, rv2;

    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;

    // Reset values.
    @(posedge PCLK);
    @(negedge PCLK);
    check_val("rst_psel", PSEL, 1'b0);
    check_val("rst_penable", PENABLE, 1'b0);
    check_val("rst_pwrite", PWRITE, 1'b0);
    check_val("rst_paddr", PADDR, 0);
    check_val("rst_pwdata", PWDATA, 0);
    check_val("rst_cmd_ready", cmd_ready, 1'b1);
    check_val("rst_rsp_valid", rsp_valid, 1'b0);
    check_val("rst_rsp_rdata", rsp_rdata, 0);
    check_val("rst_rsp_err", rsp_err, 1'b0);
    check_val("rst_rsp_timeout", rsp_timeout, 1'b0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Zero-wait write.
    send(1'b1, 8'h02, 32'hCAFEBABE, 0, 32'h1111_2222, 1'b0, 1'b0, c1, rv1);
    check_val("wr_setup_psel", PSEL, 1'b1);
    check_val("wr_setup_penable", PENABLE, 1'b0);
    check_val("wr_setup_paddr", PADDR, 8'h02);
    check_val("wr_setup_pwdata", PWDATA, 32'hCAFEBABE);
    check_val("wr_setup_pwrite", PWRITE, 1'b1);
    check_val("wr_setup_ready", cmd_ready, 1'b0);
    @(negedge PCLK);
    check_val("wr_access_penable", PENABLE, 1'b1);
    check_val("wr_access_paddr", PADDR, 8'h02);
    wait_rsp();
    check_val("wr_idle_psel", PSEL, 1'b0);
    check_val("wr_idle_ready", cmd_ready, 1'b1);
    @(negedge PCLK);
    check_val("wr_rsp_one_cycle", rsp_valid, 1'b0);

    // Read with two wait states; PWDATA keeps the previous write.
    send(1'b0, 8'h05, 32'h0000_0000, 2, 32'hFEEDBEEF, 1'b0, 1'b0, c1, rv1);
    check_val("rd_setup_pwrite", PWRITE, 1'b0);
    check_val("rd_setup_paddr", PADDR, 8'h05);
    check_val("rd_setup_pwdata", PWDATA, 32'hCAFEBABE);
    wait_rsp();
    check_val("rd_penable_cycles", last_en_run, 3);

    // Slave error on a write.
    send(1'b1, 8'h20, 32'h0BADF00D, 1, 32'h7777_7777, 1'b1, 1'b0, c1, rv1);
    wait_rsp();
    check_val("err_penable_cycles", last_en_run, 2);

    // Slave error on a read still returns PRDATA.
    send(1'b0, 8'h21, 32'h0, 0, 32'h2468ACE0, 1'b1, 1'b0, c1, rv1);
    wait_rsp();

    // Back-to-back writes with cmd_valid held.
    send(1'b1, 8'h03, 32'hABCD1234, 0, 32'h0, 1'b0, 1'b0, c1, rv1);
    send(1'b1, 8'h04, 32'h12345678, 0, 32'h0, 1'b0, 1'b0, c2, rv2);
    check_val("b2b_accept_in_rsp", rv2, 1'b1);
    check_val("b2b_accept_spacing", c2 - c1, 3);
    check_val("b2b_setup_paddr", PADDR, 8'h04);
    wait_rsp();
    check_val("b2b_psel_gap", last_gap, 1);
    check_val("b2b_pwdata_hold", PWDATA, 32'h12345678);

    // Reset in the middle of ACCESS drops the transfer.
    send(1'b0, 8'h07, 32'h0, 3, 32'h5555AAAA, 1'b0, 1'b0, c1, rv1);
    @(negedge PCLK);
    check_val("mid_rst_in_access", PENABLE, 1'b1);
    exp_q.delete();
    PRESET = 1'b1;
    @(negedge PCLK);
    check_val("mid_rst_psel", PSEL, 1'b0);
    check_val("mid_rst_penable", PENABLE, 1'b0);
    check_val("mid_rst_ready", cmd_ready, 1'b1);
    check_val("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check_val("mid_rst_pwdata", PWDATA, 0);
    PRESET = 1'b0;
    repeat (6) @(negedge PCLK);

`ifdef APB_MASTER_TIMEOUT_EN
    // Completer never answers: abort after TO stalled ACCESS cycles.
    send(1'b0, 8'h09, 32'h0, 1000, 32'h3333_4444, 1'b0, 1'b1, c1, rv1);
    wait_rsp();
    check_val("to_penable_cycles", last_en_run, TO);
    check_val("to_psel_dropped", PSEL, 1'b0);
    check_val("to_ready", cmd_ready, 1'b1);
`else
    // Long stall completes normally; no timeout in this build.
    send(1'b0, 8'h09, 32'h0, 6, 32'h13579BDF, 1'b0, 1'b0, c1, rv1);
    wait_rsp();
    check_val("long_penable_cycles", last_en_run, 7);
`endif

    // A normal transfer after the reset/abort path.
    send(1'b1, 8'h0A, 32'h0F0F_F0F0, 0, 32'h0, 1'b0, 1'b0, c1, rv1);
    wait_rsp();
    check_val("final_pwdata", PWDATA, 32'h0F0F_F0F0);

    repeat (3) @(negedge PCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
